// File: rtl/cart_autodetect_if.sv
// ROM read-port bundle between the console fetch path, the detector and the ROM RAM port B.
// master = detector side (drives the RAM address and console data); slave = surroundings.
interface cart_autodetect_if;
    logic [14:0] cpu_rom_a;
    logic [7:0]  cpu_rom_do;
    logic [14:0] ram_a;
    logic [7:0]  ram_q;

    modport master (input cpu_rom_a, input ram_q, output cpu_rom_do, output ram_a);
    modport slave  (output cpu_rom_a, output ram_q, input cpu_rom_do, input ram_a);
endinterface

// File: rtl/cart_autodetect.sv
// Post-download ROM scanner: picks the bankswitch scheme and SuperChip flag for the console core.
// Define SIG_DETECT_EN to add opcode-signature detection (E0 / 3F schemes) on top of the size table.
module cart_autodetect #(
    parameter int RD_LAT     = 1,
    parameter int SCAN_LIMIT = 32768,
    parameter int SIG_MIN    = 2
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 dl_active,
    input  logic [16:0]          rom_size,
    input  logic [3:0]           ext_bs,
    input  logic [1:0]           sc_mode,
    cart_autodetect_if.master    bus,
    output logic                 hold_reset,
    output logic [3:0]           force_bs,
    output logic                 sc,
    output logic                 busy
);

    if (RD_LAT < 1 || RD_LAT > 2 || SIG_MIN < 0 || SIG_MIN > 15) begin : g_bad_param
        $error("cart_autodetect: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DECIDE} state_t;

    state_t            state_q, state_d;
    logic              dl_q;
    logic [16:0]       n_q, n_d;
    logic [3:0]        ext_q, ext_d;
    logic [1:0]        scm_q, scm_d;
    logic [14:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [8:0]        rcnt_q, rcnt_d;
    logic [1:0]        drain_q, drain_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT:0]   vld_pipe;
    logic [7:0]        byte0_q, byte0_d;
    logic              sc_ok_q, sc_ok_d;
    logic              busy_q, busy_d;
    logic              sc_q, sc_d;
    logic [3:0]        bs_q, bs_d;
    logic              issue, consume, sc_det;
    logic [3:0]        auto_bs;

`ifdef SIG_DETECT_EN
    localparam logic [3:0] SIG_MIN4 = 4'(SIG_MIN);
    logic [7:0] w1_q, w1_d, w2_q, w2_d;
    logic [3:0] hit3f_q, hit3f_d, hite0_q, hite0_d;
`endif

    function automatic logic [3:0] size_bs(input logic [16:0] n);
        case (n)
            17'd8192:  size_bs = 4'd1;
            17'd12288: size_bs = 4'd8;
            17'd16384: size_bs = 4'd2;
            17'd32768: size_bs = 4'd6;
            default:   size_bs = 4'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        ext_d   = ext_q;
        scm_d   = scm_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        drain_d = drain_q;
        byte0_d = byte0_q;
        sc_ok_d = sc_ok_q;
        busy_d  = busy_q;
        sc_d    = sc_q;
        bs_d    = bs_q;
`ifdef SIG_DETECT_EN
        w1_d    = w1_q;
        w2_d    = w2_q;
        hit3f_d = hit3f_q;
        hite0_d = hite0_q;
`endif

        // Read data returns RD_LAT cycles after its address was issued.
        issue    = (state_q == SCAN);
        vld_pipe = {vld_q, issue};
        vld_d    = vld_pipe[RD_LAT-1:0];
        consume  = vld_pipe[RD_LAT];

        if (consume) begin
            if (!rcnt_q[8]) rcnt_d = rcnt_q + 9'd1;
            if (rcnt_q == 9'd0) byte0_d = bus.ram_q;
            else if (!rcnt_q[8] && bus.ram_q != byte0_q) sc_ok_d = 1'b0;
`ifdef SIG_DETECT_EN
            if (w1_q == 8'h85 && bus.ram_q == 8'h3F && hit3f_q != 4'hF)
                hit3f_d = hit3f_q + 4'd1;
            if ((w2_q == 8'h8D || w2_q == 8'hAD) && w1_q[7:3] == 5'b11100 &&
                (bus.ram_q == 8'h1F || bus.ram_q == 8'hFF) && hite0_q != 4'hF)
                hite0_d = hite0_q + 4'd1;
            w2_d = w1_q;
            w1_d = bus.ram_q;
`endif
        end

        sc_det  = sc_ok_q && (n_q >= 17'd8192);
        auto_bs = size_bs(n_q);
`ifdef SIG_DETECT_EN
        if (n_q == 17'd8192) begin
            if (hite0_q >= SIG_MIN4)      auto_bs = 4'd4;
            else if (hit3f_q >= SIG_MIN4) auto_bs = 4'd5;
        end else if (n_q > 17'd8192 && auto_bs == 4'd0 && hit3f_q >= SIG_MIN4) begin
            auto_bs = 4'd5;
        end
`endif

        case (state_q)
            IDLE: if (dl_q && !dl_active) begin
                n_d     = (rom_size > 17'(SCAN_LIMIT)) ? 17'(SCAN_LIMIT) : rom_size;
                ext_d   = ext_bs;
                scm_d   = sc_mode;
                addr_d  = '0;
                cnt_d   = '0;
                rcnt_d  = '0;
                sc_ok_d = 1'b1;
                busy_d  = 1'b1;
`ifdef SIG_DETECT_EN
                w1_d    = '0;
                w2_d    = '0;
                hit3f_d = '0;
                hite0_d = '0;
`endif
                state_d = (n_d == 17'd0) ? DECIDE : SCAN;
            end
            SCAN: begin
                addr_d = addr_q + 15'd1;
                cnt_d  = cnt_q + 16'd1;
                if ({1'b0, cnt_q} == n_q - 17'd1) begin
                    state_d = DRAIN;
                    drain_d = 2'(RD_LAT - 1);
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) state_d = DECIDE;
                else                 drain_d = drain_q - 2'd1;
            end
            DECIDE: begin
                bs_d    = (ext_q != 4'd0) ? ext_q : auto_bs;
                sc_d    = (scm_q == 2'd1) ? 1'b0 : (scm_q == 2'd2) ? 1'b1 : sc_det;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new download aborts any scan; previous decisions are kept.
        if (state_q != IDLE && dl_active) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            vld_d   = '0;
            bs_d    = bs_q;
            sc_d    = sc_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dl_q    <= 1'b0;
            n_q     <= '0;
            ext_q   <= '0;
            scm_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            drain_q <= '0;
            vld_q   <= '0;
            byte0_q <= '0;
            sc_ok_q <= 1'b0;
            busy_q  <= 1'b0;
            sc_q    <= 1'b0;
            bs_q    <= '0;
`ifdef SIG_DETECT_EN
            w1_q    <= '0;
            w2_q    <= '0;
            hit3f_q <= '0;
            hite0_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dl_q    <= dl_active;
            n_q     <= n_d;
            ext_q   <= ext_d;
            scm_q   <= scm_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            drain_q <= drain_d;
            vld_q   <= vld_d;
            byte0_q <= byte0_d;
            sc_ok_q <= sc_ok_d;
            busy_q  <= busy_d;
            sc_q    <= sc_d;
            bs_q    <= bs_d;
`ifdef SIG_DETECT_EN
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            hit3f_q <= hit3f_d;
            hite0_q <= hite0_d;
`endif
        end
    end

    assign bus.ram_a      = busy_q ? addr_q : bus.cpu_rom_a;
    assign bus.cpu_rom_do = busy_q ? 8'h00 : bus.ram_q;
    assign hold_reset     = busy_q | dl_active;
    assign busy           = busy_q;
    assign force_bs       = bs_q;
    assign sc             = sc_q;

endmodule

// File: tb/tb_cart_autodetect.sv
// Directed bench for cart_autodetect: size table, SuperChip detect, overrides, abort and reset.
module tb_cart_autodetect;
    localparam int RD_LAT = 1;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        dl_active = 1'b0;
    logic [16:0] rom_size  = '0;
    logic [3:0]  ext_bs    = '0;
    logic [1:0]  sc_mode   = '0;
    logic        hold_reset, sc, busy;
    logic [3:0]  force_bs;
    logic [7:0]  mem [0:32767];
    int          n_checks = 0;
    int          n_fail   = 0;

    cart_autodetect_if bus();

    cart_autodetect #(.RD_LAT(RD_LAT)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .rom_size   (rom_size),
        .ext_bs     (ext_bs),
        .sc_mode    (sc_mode),
        .bus        (bus.master),
        .hold_reset (hold_reset),
        .force_bs   (force_bs),
        .sc         (sc),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // ROM RAM port B model, one cycle of read latency.
    always @(posedge clk_sys) bus.ram_q <= mem[bus.ram_a];

    task automatic fill_random();
        for (int i = 0; i < 32768; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == 8'h85 || b == 8'h8D || b == 8'hAD) b = 8'h00;
            mem[i] = b;
        end
    endtask

    task automatic start_dl(input int size, input logic [3:0] ext, input logic [1:0] scm);
        @(negedge clk_sys);
        dl_active = 1'b1;
        rom_size  = 17'(size);
        ext_bs    = ext;
        sc_mode   = scm;
        repeat (3) begin
            @(negedge clk_sys);
            n_checks++;
            if (hold_reset !== 1'b1) begin n_fail++; $display("FAIL hold_during_dl: got %b want 1", hold_reset); end
        end
        dl_active = 1'b0;
    endtask

    task automatic run_busy(input int n, output int cyc, output int aerr, output int derr, output int herr);
        int w;
        w = 0; cyc = 0; aerr = 0; derr = 0; herr = 0;
        @(negedge clk_sys);
        while (busy !== 1'b1 && w < 8) begin @(negedge clk_sys); w++; end
        while (busy === 1'b1 && cyc < 40000) begin
            if (cyc < n && bus.ram_a !== 15'(cyc)) aerr++;
            if (bus.cpu_rom_do !== 8'h00) derr++;
            if (hold_reset !== 1'b1) herr++;
            cyc++;
            @(negedge clk_sys);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h5ABC]  = 8'hC3;
        bus.cpu_rom_a  = 15'h5ABC;
        #1;
        n_checks += 5;
        if (force_bs !== 4'd0)   begin n_fail++; $display("FAIL rst_bs: got %0d want 0", force_bs); end
        if (sc !== 1'b0)         begin n_fail++; $display("FAIL rst_sc: got %b want 0", sc); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (hold_reset !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %b want 0", hold_reset); end
        if (bus.ram_a !== 15'h5ABC) begin n_fail++; $display("FAIL rst_ram_a: got %h want 5abc", bus.ram_a); end
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_checks++;
        if (bus.cpu_rom_do !== 8'hC3) begin n_fail++; $display("FAIL rst_passthru: got %h want c3", bus.cpu_rom_do); end
    endtask

    task automatic test_size_4k();
        int cyc, ae, de, he;
        start_dl(4096, 4'd0, 2'd0);
        run_busy(4096, cyc, ae, de, he);
        n_checks += 6;
        if (cyc !== 4096 + RD_LAT + 1) begin n_fail++; $display("FAIL 4k_busy_len: got %0d want %0d", cyc, 4096 + RD_LAT + 1); end
        if (ae !== 0) begin n_fail++; $display("FAIL 4k_scan_addr: got %0d bad addresses want 0", ae); end
        if (de !== 0) begin n_fail++; $display("FAIL 4k_do_zero: got %0d nonzero want 0", de); end
        if (he !== 0) begin n_fail++; $display("FAIL 4k_hold: got %0d low cycles want 0", he); end
        if (force_bs !== 4'd0) begin n_fail++; $display("FAIL 4k_bs: got %0d want 0", force_bs); end
        if (sc !== 1'b0) begin n_fail++; $display("FAIL 4k_sc: got %b want 0", sc); end
        @(negedge clk_sys);
        n_checks += 3;
        if (bus.ram_a !== 15'h5ABC) begin n_fail++; $display("FAIL 4k_mux_a: got %h want 5abc", bus.ram_a); end
        if (bus.cpu_rom_do !== 8'hC3) begin n_fail++; $display("FAIL 4k_mux_do: got %h want c3", bus.cpu_rom_do); end
        if (hold_reset !== 1'b0) begin n_fail++; $display("FAIL 4k_hold_after: got %b want 0", hold_reset); end
    endtask

    task automatic test_sc_8k();
        int cyc, ae, de, he;
        fill_random();
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        mem[256] = 8'h00;
        start_dl(8192, 4'd0, 2'd0);
        run_busy(8192, cyc, ae, de, he);
        n_checks += 4;
        if (cyc !== 8192 + RD_LAT + 1) begin n_fail++; $display("FAIL 8k_busy_len: got %0d want %0d", cyc, 8192 + RD_LAT + 1); end
        if (ae !== 0) begin n_fail++; $display("FAIL 8k_scan_addr: got %0d bad want 0", ae); end
        if (force_bs !== 4'd1) begin n_fail++; $display("FAIL 8k_bs: got %0d want 1", force_bs); end
        if (sc !== 1'b1) begin n_fail++; $display("FAIL 8k_sc: got %b want 1", sc); end
        mem[8'h80] = 8'h00;
        start_dl(8192, 4'd0, 2'd0);
        run_busy(8192, cyc, ae, de, he);
        n_checks += 2;
        if (force_bs !== 4'd1) begin n_fail++; $display("FAIL 8k_bad_bs: got %0d want 1", force_bs); end
        if (sc !== 1'b0) begin n_fail++; $display("FAIL 8k_bad_sc: got %b want 0", sc); end
    endtask

    task automatic test_ext_override();
        int cyc, ae, de, he;
        start_dl(16384, 4'd5, 2'd2);
        run_busy(16384, cyc, ae, de, he);
        n_checks += 4;
        if (cyc !== 16384 + RD_LAT + 1) begin n_fail++; $display("FAIL ext_busy_len: got %0d want %0d", cyc, 16384 + RD_LAT + 1); end
        if (he !== 0) begin n_fail++; $display("FAIL ext_hold: got %0d low cycles want 0", he); end
        if (force_bs !== 4'd5) begin n_fail++; $display("FAIL ext_bs: got %0d want 5", force_bs); end
        if (sc !== 1'b1) begin n_fail++; $display("FAIL ext_sc: got %b want 1", sc); end
    endtask

    task automatic test_abort();
        int cyc, ae, de, he, w;
        start_dl(8192, 4'd3, 2'd1);
        w = 0;
        @(negedge clk_sys);
        while (!(busy === 1'b1 && bus.ram_a === 15'h0400) && w < 20000) begin @(negedge clk_sys); w++; end
        n_checks++;
        if (w >= 20000) begin n_fail++; $display("FAIL abort_reach_400: got timeout want addr 400"); end
        dl_active = 1'b1;
        @(negedge clk_sys);
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (force_bs !== 4'd5) begin n_fail++; $display("FAIL abort_bs: got %0d want 5", force_bs); end
        if (sc !== 1'b1) begin n_fail++; $display("FAIL abort_sc: got %b want 1", sc); end
        if (hold_reset !== 1'b1) begin n_fail++; $display("FAIL abort_hold: got %b want 1", hold_reset); end
        start_dl(100, 4'd0, 2'd0);
        run_busy(100, cyc, ae, de, he);
        n_checks += 4;
        if (cyc !== 100 + RD_LAT + 1) begin n_fail++; $display("FAIL restart_len: got %0d want %0d", cyc, 100 + RD_LAT + 1); end
        if (ae !== 0) begin n_fail++; $display("FAIL restart_addr: got %0d bad want 0", ae); end
        if (force_bs !== 4'd0) begin n_fail++; $display("FAIL restart_bs: got %0d want 0", force_bs); end
        if (sc !== 1'b0) begin n_fail++; $display("FAIL restart_sc: got %b want 0", sc); end
    endtask

    task automatic test_clamp_32k();
        int cyc, ae, de, he;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        start_dl(40000, 4'd0, 2'd1);
        run_busy(32768, cyc, ae, de, he);
        n_checks += 4;
        if (cyc !== 32768 + RD_LAT + 1) begin n_fail++; $display("FAIL clamp_len: got %0d want %0d", cyc, 32768 + RD_LAT + 1); end
        if (ae !== 0) begin n_fail++; $display("FAIL clamp_addr: got %0d bad want 0", ae); end
        if (force_bs !== 4'd6) begin n_fail++; $display("FAIL clamp_bs: got %0d want 6", force_bs); end
        if (sc !== 1'b0) begin n_fail++; $display("FAIL clamp_sc_forced_off: got %b want 0", sc); end
    endtask

    task automatic test_reset_mid_scan();
        start_dl(4096, 4'd0, 2'd2);
        repeat (50) @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (force_bs !== 4'd0) begin n_fail++; $display("FAIL midrst_bs: got %0d want 0", force_bs); end
        if (sc !== 1'b0) begin n_fail++; $display("FAIL midrst_sc: got %b want 0", sc); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (bus.ram_a !== 15'h5ABC) begin n_fail++; $display("FAIL midrst_ram_a: got %h want 5abc", bus.ram_a); end
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic test_size_zero();
        int cyc, ae, de, he;
        start_dl(0, 4'd0, 2'd2);
        run_busy(0, cyc, ae, de, he);
        n_checks += 3;
        if (cyc !== 1) begin n_fail++; $display("FAIL zero_busy_len: got %0d want 1", cyc); end
        if (force_bs !== 4'd0) begin n_fail++; $display("FAIL zero_bs: got %0d want 0", force_bs); end
        if (sc !== 1'b1) begin n_fail++; $display("FAIL zero_sc_forced_on: got %b want 1", sc); end
    endtask

`ifdef SIG_DETECT_EN
    task automatic test_signatures();
        int cyc, ae, de, he;
        fill_random();
        mem[16'h100] = 8'h85; mem[16'h101] = 8'h3F;
        mem[16'h900] = 8'h85; mem[16'h901] = 8'h3F;
        mem[16'h200] = 8'h8D; mem[16'h201] = 8'hE0; mem[16'h202] = 8'h1F;
        mem[16'h300] = 8'h8D; mem[16'h301] = 8'hE0; mem[16'h302] = 8'h1F;
        start_dl(8192, 4'd0, 2'd0);
        run_busy(8192, cyc, ae, de, he);
        n_checks++;
        if (force_bs !== 4'd4) begin n_fail++; $display("FAIL sig_e0: got %0d want 4", force_bs); end
        mem[16'h200] = 8'h00; mem[16'h300] = 8'h00;
        start_dl(8192, 4'd0, 2'd0);
        run_busy(8192, cyc, ae, de, he);
        n_checks++;
        if (force_bs !== 4'd5) begin n_fail++; $display("FAIL sig_3f: got %0d want 5", force_bs); end
    endtask
`endif

    initial begin
        test_reset();
        test_size_4k();
        test_sc_8k();
        test_ext_override();
        test_abort();
        test_clamp_32k();
        test_reset_mid_scan();
        test_size_zero();
`ifdef SIG_DETECT_EN
        test_signatures();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
